// File: rtl/hit_collector_if.sv
// hit_collector_if: candidate tags and checker results in, FIFO readout and drop accounting out.
interface hit_collector_if #(
   parameter int TAG_W = 48,
   parameter int DEPTH = 16
);
   logic                   in_valid;
   logic [TAG_W-1:0]       A_tag;
   logic [TAG_W-1:0]       B_tag;
   logic                   A_hit;
   logic                   B_hit;
   logic                   out_valid;
   logic                   out_ready;
   logic [TAG_W-1:0]       out_tag;
   logic                   out_port;
   logic [$clog2(DEPTH):0] pending;
   logic                   overflow;
   logic [15:0]            drop_count;
   logic                   clr_overflow;
   modport master (
      output in_valid, A_tag, B_tag, A_hit, B_hit, out_ready, clr_overflow,
      input  out_valid, out_tag, out_port, pending, overflow, drop_count
   );
   modport slave (
      input  in_valid, A_tag, B_tag, A_hit, B_hit, out_ready, clr_overflow,
      output out_valid, out_tag, out_port, pending, overflow, drop_count
   );
endinterface

// File: rtl/hit_collector.sv
// hit_collector: aligns candidate tags with delayed checker hits and queues them in a FWFT FIFO
// with sticky overflow and a saturating drop counter.
module hit_collector #(
   parameter int TAG_W   = 48,
   parameter int LATENCY = 3,
   parameter int DEPTH   = 16
) (
   input logic clk,
   input logic rst,
   hit_collector_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
   localparam logic [PW-1:0] TWO = PW'(2);
   logic [LATENCY-1:0] v;
   logic [TAG_W-1:0]   ta [LATENCY];
   logic [TAG_W-1:0]   tb [LATENCY];
   logic [TAG_W:0]     mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [PW-1:0]      pending;
   logic [PW-1:0]      free;
   logic               overflow;
   logic [15:0]        drop_count;
   logic               pa;
   logic               pb;
   logic               wa;
   logic               wb;
   logic               pop;
   logic [1:0]         nw;
   logic [1:0]         nd;
   logic [16:0]        sum;
   always_ff @(posedge clk) begin
      ta[0] <= bus.A_tag;
      tb[0] <= bus.B_tag;
      for (int i = 1; i < LATENCY; i++) begin
         ta[i] <= ta[i-1];
         tb[i] <= tb[i-1];
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         v <= '0;
      end else begin
         v[0] <= bus.in_valid;
         for (int i = 1; i < LATENCY; i++) v[i] <= v[i-1];
      end
   end
   // Room is judged on pre-pop occupancy; A is served before B.
   always_comb begin
      pa  = v[LATENCY-1] & bus.A_hit;
      pb  = v[LATENCY-1] & bus.B_hit;
      free = DEPTH_P - pending;
      wa  = pa & (free != '0);
      wb  = pb & (pa ? (free >= TWO) : (free != '0));
      nw  = {1'b0, wa} + {1'b0, wb};
      nd  = {1'b0, pa & ~wa} + {1'b0, pb & ~wb};
      pop = (pending != '0) & bus.out_ready;
      sum = {1'b0, drop_count} + {15'd0, nd};
   end
   always_ff @(posedge clk) begin
      if (wa) mem[wr_ptr] <= {ta[LATENCY-1], 1'b0};
      if (wb) mem[wa ? wr_ptr + AW'(1) : wr_ptr] <= {tb[LATENCY-1], 1'b1};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         pending    <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         wr_ptr  <= wr_ptr + AW'(nw);
         rd_ptr  <= rd_ptr + AW'(pop);
         pending <= pending + PW'(nw) - PW'(pop);
         if (nd != 2'd0) begin
            overflow   <= 1'b1;
            drop_count <= bus.clr_overflow ? {14'd0, nd} : (sum[16] ? 16'hFFFF : sum[15:0]);
         end else if (bus.clr_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
         end
      end
   end
   assign bus.out_valid  = pending != '0;
   assign bus.out_tag    = mem[rd_ptr][TAG_W:1];
   assign bus.out_port   = mem[rd_ptr][0];
   assign bus.pending    = pending;
   assign bus.overflow   = overflow;
   assign bus.drop_count = drop_count;
endmodule

// File: tb/tb_hit_collector.sv
// tb_hit_collector: directed checks of alignment, ordering, overflow, saturation and reset.
module tb_hit_collector;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   hit_collector_if #(.TAG_W(48), .DEPTH(16)) bus ();
   hit_collector #(.TAG_W(48), .LATENCY(3), .DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   // n consecutive valid cycles with hits held; the delay line is flushed before returning.
   task automatic burst(input int n, input logic ha, input logic hb, input logic [47:0] base);
      bus.A_hit = ha;
      bus.B_hit = hb;
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.A_tag = base + 48'(2 * i);
         bus.B_tag = base + 48'(2 * i + 1);
         step();
      end
      bus.in_valid = 1'b0;
      repeat (3) step();
      bus.A_hit = 1'b0;
      bus.B_hit = 1'b0;
   endtask
   initial begin
      bus.in_valid = 0; bus.A_tag = 0; bus.B_tag = 0; bus.A_hit = 0; bus.B_hit = 0;
      bus.out_ready = 0; bus.clr_overflow = 0;
      repeat (2) step();
      rst = 0;
      check("rst_valid", bus.out_valid, 0);
      check("rst_pending", bus.pending, 0);
      check("rst_overflow", bus.overflow, 0);
      check("rst_drops", bus.drop_count, 0);
      bus.out_ready = 1;
      bus.in_valid = 1; bus.A_tag = 48'h123; bus.B_tag = 48'h124;
      step();
      bus.in_valid = 0;
      check("single_early0", bus.out_valid, 0);
      step();
      check("single_early1", bus.out_valid, 0);
      step();
      check("single_early2", bus.out_valid, 0);
      bus.A_hit = 1;
      step();
      bus.A_hit = 0;
      check("single_valid", bus.out_valid, 1);
      check("single_tag", bus.out_tag, 48'h123);
      check("single_port", bus.out_port, 0);
      check("single_pending", bus.pending, 1);
      step();
      check("single_popped", bus.pending, 0);
      check("single_no_b", bus.out_valid, 0);
      bus.out_ready = 0;
      burst(1, 1, 1, 48'h10);
      check("dual_pending", bus.pending, 2);
      check("dual_tag0", bus.out_tag, 48'h10);
      check("dual_port0", bus.out_port, 0);
      bus.out_ready = 1;
      step();
      check("dual_tag1", bus.out_tag, 48'h11);
      check("dual_port1", bus.out_port, 1);
      check("dual_pending1", bus.pending, 1);
      step();
      check("dual_empty", bus.out_valid, 0);
      bus.out_ready = 0;
      burst(8, 1, 1, 48'h100);
      check("fill_pending", bus.pending, 16);
      check("fill_no_drop", bus.drop_count, 0);
      burst(1, 1, 1, 48'h200);
      check("full_dual_drop", bus.drop_count, 2);
      burst(3, 1, 0, 48'h300);
      check("full_pending", bus.pending, 16);
      check("full_drops", bus.drop_count, 5);
      check("full_overflow", bus.overflow, 1);
      bus.out_ready = 1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("order_tag%0d", i), bus.out_tag, 48'h100 + 48'(i));
         check($sformatf("order_port%0d", i), bus.out_port, 64'(i % 2));
         step();
      end
      bus.out_ready = 0;
      check("drain_empty", bus.pending, 0);
      bus.clr_overflow = 1;
      step();
      bus.clr_overflow = 0;
      check("clr_overflow", bus.overflow, 0);
      check("clr_drops", bus.drop_count, 0);
      burst(7, 1, 1, 48'h800);
      burst(1, 1, 0, 48'h900);
      check("odd_pre", bus.pending, 15);
      burst(1, 1, 1, 48'h400);
      check("odd_pending", bus.pending, 16);
      check("odd_drops", bus.drop_count, 1);
      bus.in_valid = 1; bus.A_tag = 48'h500;
      step();
      bus.in_valid = 0;
      repeat (2) step();
      bus.A_hit = 1; bus.out_ready = 1;
      step();
      bus.A_hit = 0; bus.out_ready = 0;
      check("poppush_pending", bus.pending, 15);
      check("poppush_drops", bus.drop_count, 2);
      burst(1, 1, 0, 48'h600);
      check("refill", bus.pending, 16);
      bus.in_valid = 1;
      step();
      bus.in_valid = 0;
      repeat (2) step();
      bus.A_hit = 1; bus.B_hit = 1; bus.clr_overflow = 1;
      step();
      bus.A_hit = 0; bus.B_hit = 0; bus.clr_overflow = 0;
      check("clrdrop_drops", bus.drop_count, 2);
      check("clrdrop_overflow", bus.overflow, 1);
      bus.clr_overflow = 1;
      step();
      bus.clr_overflow = 0;
      burst(32767, 1, 1, 48'h0);
      check("preload_fffe", bus.drop_count, 16'hFFFE);
      burst(1, 1, 1, 48'h0);
      check("saturate", bus.drop_count, 16'hFFFF);
      burst(1, 1, 0, 48'h0);
      check("saturate_hold", bus.drop_count, 16'hFFFF);
      bus.out_ready = 1;
      repeat (11) step();
      bus.out_ready = 0;
      check("pre_reset_pending", bus.pending, 5);
      bus.in_valid = 1;
      repeat (2) step();
      bus.in_valid = 0; bus.A_hit = 1; bus.B_hit = 1; rst = 1;
      step();
      rst = 0;
      check("reset_pending", bus.pending, 0);
      check("reset_valid", bus.out_valid, 0);
      check("reset_drops", bus.drop_count, 0);
      check("reset_overflow", bus.overflow, 0);
      repeat (5) step();
      check("gated_pending", bus.pending, 0);
      check("gated_valid", bus.out_valid, 0);
      check("gated_drops", bus.drop_count, 0);
      bus.A_hit = 0; bus.B_hit = 0;
      burst(1, 0, 1, 48'h700);
      check("post_reset_pending", bus.pending, 1);
      check("post_reset_tag", bus.out_tag, 48'h701);
      check("post_reset_port", bus.out_port, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
